// File: rtl/hazard_pkg.sv
// Shared constants, stage-record types and the writer-match helper for the
// hazard/forwarding controller.
package hazard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [1:0] WB_DMEM  = 2'b00;
    localparam logic [1:0] WB_ALU   = 2'b01;
    localparam logic [1:0] WB_PC4   = 2'b10;

    // Register indices are held zero-extended to this width inside the records.
    localparam int RD_MAX_W = 8;
    typedef logic [RD_MAX_W-1:0] rd_t;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic [1:0] wbsel;
        rd_t        rd;
    } stage_rec_t;

    typedef struct packed {
        rd_t  rs1;
        rd_t  rs2;
        logic use_rs1;
        logic use_rs2;
        logic asel;
        logic bsel;
    } ex_src_t;

    function automatic logic writes(stage_rec_t rec, rd_t r);
        return rec.valid && rec.regwrite && (rec.rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// MEM/WB priority match for one source register; MEM only forwards ALU results.
module fwd_select
    import hazard_pkg::*;
(
    input  rd_t        rs,
    input  stage_rec_t mem,
    input  stage_rec_t wb,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_NONE;
        if (writes(mem, rs) && (mem.wbsel == WB_ALU))
            sel = FWD_MEM;
        // 2'b11 is not a defined writeback source, so it never forwards
        else if (writes(wb, rs) && (wb.wbsel != 2'b11))
            sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller: EX/MEM/WB metadata pipeline, operand
// forwarding selects, one-cycle load/link-use stall and branch flush.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic [1:0]       id_wbsel,
    input  logic             id_asel,
    input  logic             id_bsel,
    input  logic             flush,
    input  logic             ext_hold,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [1:0]       forward_rs2,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             bubble_ex,
    output logic [CNT_W-1:0] stall_count
);

    stage_rec_t ex_rec, mem_rec, wb_rec;
    ex_src_t    ex_src;
    logic       hazard;
    logic [1:0] sel_a, sel_b, sel_rs2;

    // Producer in EX whose result is not ready for ALU-path forwarding next cycle
    always_comb begin
        hazard = 1'b0;
        if (id_valid && !flush && writes(ex_rec, ex_rec.rd) && (ex_rec.wbsel != WB_ALU))
            hazard = (id_use_rs1 && (rd_t'(id_rs1) == ex_rec.rd)) ||
                     (id_use_rs2 && (rd_t'(id_rs2) == ex_rec.rd));
    end

    assign stall_pc   = hazard;
    assign stall_ifid = hazard;
    assign bubble_ex  = hazard;

    fwd_select u_fwd_a (
        .rs  (ex_src.rs1),
        .mem (mem_rec),
        .wb  (wb_rec),
        .sel (sel_a)
    );

    fwd_select u_fwd_b (
        .rs  (ex_src.rs2),
        .mem (mem_rec),
        .wb  (wb_rec),
        .sel (sel_b)
    );

    fwd_select u_fwd_rs2 (
        .rs  (ex_src.rs2),
        .mem (mem_rec),
        .wb  (wb_rec),
        .sel (sel_rs2)
    );

    assign forward_a   = (ex_src.use_rs1 && !ex_src.asel) ? sel_a : FWD_NONE;
    assign forward_b   = (ex_src.use_rs2 && !ex_src.bsel) ? sel_b : FWD_NONE;
    assign forward_rs2 = ex_src.use_rs2 ? sel_rs2 : FWD_NONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rec      <= '0;
            ex_src      <= '0;
            mem_rec     <= '0;
            wb_rec      <= '0;
            stall_count <= '0;
        end else if (!ext_hold) begin
            wb_rec  <= mem_rec;
            mem_rec <= ex_rec;
            if (hazard || flush) begin
                ex_rec <= '0;
                ex_src <= '0;
            end else begin
                ex_rec <= '{valid: id_valid, regwrite: id_regwrite,
                            wbsel: id_wbsel, rd: rd_t'(id_rd)};
                ex_src <= '{rs1: rd_t'(id_rs1), rs2: rd_t'(id_rs2),
                            use_rs1: id_use_rs1, use_rs2: id_use_rs2,
                            asel: id_asel, bsel: id_bsel};
            end
            if (hazard && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed instruction sequences with literal
// expectations plus a randomized run against an instruction-history model.
module tb_hazard_fwd_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [REG_W-1:0] id_rs1, id_rs2, id_rd;
    logic             id_use_rs1, id_use_rs2, id_regwrite;
    logic [1:0]       id_wbsel;
    logic             id_asel, id_bsel;
    logic             flush, ext_hold;
    logic [1:0]       forward_a, forward_b, forward_rs2;
    logic             stall_pc, stall_ifid, bubble_ex;
    logic [CNT_W-1:0] stall_count;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_wbsel    (id_wbsel),
        .id_asel     (id_asel),
        .id_bsel     (id_bsel),
        .flush       (flush),
        .ext_hold    (ext_hold),
        .forward_a   (forward_a),
        .forward_b   (forward_b),
        .forward_rs2 (forward_rs2),
        .stall_pc    (stall_pc),
        .stall_ifid  (stall_ifid),
        .bubble_ex   (bubble_ex),
        .stall_count (stall_count)
    );

    typedef struct {
        bit v;
        int rs1;
        bit u1;
        int rs2;
        bit u2;
        int rd;
        bit rw;
        int wbsel;
        bit asel;
        bit bsel;
    } ins_t;

    // Instructions that entered EX, oldest first: last = EX, then MEM, then WB.
    ins_t hist[$];
    int   m_cnt;
    int   checks = 0;
    int   fails  = 0;
    ins_t m_next;
    bit   m_hz;

    function automatic ins_t mk(bit v, int rs1, bit u1, int rs2, bit u2,
                                int rd, bit rw, int wbsel, bit asel, bit bsel);
        ins_t i;
        i.v = v; i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
        i.rd = rd; i.rw = rw; i.wbsel = wbsel; i.asel = asel; i.bsel = bsel;
        return i;
    endfunction

    function automatic ins_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic ins_t stage(int k);
        int idx = hist.size() - 1 - k;
        if (idx < 0) return nop();
        return hist[idx];
    endfunction

    function automatic bit wr(ins_t s, int r);
        return s.v && s.rw && (s.rd == r) && (r != 0);
    endfunction

    function automatic logic [1:0] m_sel(int r);
        ins_t mem = stage(1);
        if (wr(mem, r) && mem.wbsel == 1) return 2'b10;
        if (wr(stage(2), r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_hazard();
        ins_t ex = stage(0);
        if (flush || !id_valid) return 0;
        if (!wr(ex, ex.rd) || ex.wbsel == 1) return 0;
        return (id_use_rs1 && int'(id_rs1) == ex.rd) || (id_use_rs2 && int'(id_rs2) == ex.rd);
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic apply(ins_t i, bit fl, bit hd);
        id_valid    = i.v;
        id_rs1      = REG_W'(i.rs1);
        id_rs2      = REG_W'(i.rs2);
        id_use_rs1  = i.u1;
        id_use_rs2  = i.u2;
        id_rd       = REG_W'(i.rd);
        id_regwrite = i.rw;
        id_wbsel    = 2'(i.wbsel);
        id_asel     = i.asel;
        id_bsel     = i.bsel;
        flush       = fl;
        ext_hold    = hd;
    endtask

    // Present one ID instruction for one cycle; returns mid-cycle, clock low.
    task automatic tick(ins_t i, bit fl, bit hd);
        @(posedge clk);
        #1;
        apply(i, fl, hd);
        @(negedge clk);
        #1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            m_cnt = 0;
        end else if (!ext_hold) begin
            m_hz = m_hazard();
            m_next = nop();
            if (!m_hz && !flush)
                m_next = mk(id_valid, id_rs1, id_use_rs1, id_rs2, id_use_rs2,
                            id_rd, id_regwrite, id_wbsel, id_asel, id_bsel);
            if (m_hz && m_cnt < CNT_MAX) m_cnt++;
            hist.push_back(m_next);
            if (hist.size() > 3) void'(hist.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            ins_t ex;
            logic [1:0] e_a, e_b, e_r;
            ex  = stage(0);
            e_a = (ex.u1 && !ex.asel) ? m_sel(ex.rs1) : 2'b00;
            e_b = (ex.u2 && !ex.bsel) ? m_sel(ex.rs2) : 2'b00;
            e_r = ex.u2 ? m_sel(ex.rs2) : 2'b00;
            check("model forward_a", 32'(forward_a), 32'(e_a));
            check("model forward_b", 32'(forward_b), 32'(e_b));
            check("model forward_rs2", 32'(forward_rs2), 32'(e_r));
            check("model stall_pc", 32'(stall_pc), 32'(m_hazard()));
            check("model stall_ifid", 32'(stall_ifid), 32'(m_hazard()));
            check("model bubble_ex", 32'(bubble_ex), 32'(m_hazard()));
            check("model stall_count", 32'(stall_count), 32'(m_cnt));
        end
    end

    initial begin
        ins_t add5, sub6, or7, lw5, add655, addi0, add600, beq, jal1, addi2, r;
        bit   keep, fl, hd;

        add5   = mk(1, 1, 1, 2, 1, 5, 1, 1, 0, 0);
        sub6   = mk(1, 5, 1, 3, 1, 6, 1, 1, 0, 0);
        or7    = mk(1, 0, 1, 5, 1, 7, 1, 1, 0, 0);
        lw5    = mk(1, 1, 1, 0, 0, 5, 1, 0, 0, 1);
        add655 = mk(1, 5, 1, 5, 1, 6, 1, 1, 0, 0);
        addi0  = mk(1, 1, 1, 0, 0, 0, 1, 1, 0, 1);
        add600 = mk(1, 0, 1, 0, 1, 6, 1, 1, 0, 0);
        beq    = mk(1, 5, 1, 6, 1, 0, 0, 1, 1, 1);
        jal1   = mk(1, 0, 0, 0, 0, 1, 1, 2, 1, 1);
        addi2  = mk(1, 1, 1, 0, 0, 2, 1, 1, 0, 1);

        rst = 1'b1;
        apply(nop(), 0, 0);
        #12;
        check("reset forward_a", 32'(forward_a), 0);
        check("reset forward_rs2", 32'(forward_rs2), 0);
        check("reset stall_pc", 32'(stall_pc), 0);
        check("reset stall_count", 32'(stall_count), 0);
        @(negedge clk);
        #2;
        rst = 1'b0;

        // ALU result forwarded from MEM
        tick(add5, 0, 0);
        tick(sub6, 0, 0);
        check("add-sub stall_pc", 32'(stall_pc), 0);
        tick(nop(), 0, 0);
        check("add-sub forward_a", 32'(forward_a), 32'h2);
        repeat (3) tick(nop(), 0, 0);

        // WB forward across a bubble, x0 never matches
        tick(add5, 0, 0);
        tick(nop(), 0, 0);
        tick(or7, 0, 0);
        tick(nop(), 0, 0);
        check("or forward_b", 32'(forward_b), 32'h1);
        check("or forward_a", 32'(forward_a), 32'h0);
        repeat (3) tick(nop(), 0, 0);

        // Load-use: one stall, then WB forward on both operands
        tick(lw5, 0, 0);
        tick(add655, 0, 0);
        check("load-use stall_pc", 32'(stall_pc), 1);
        check("load-use bubble_ex", 32'(bubble_ex), 1);
        check("load-use count before", 32'(stall_count), 0);
        tick(add655, 0, 0);
        check("load-use released", 32'(stall_pc), 0);
        check("load-use count after", 32'(stall_count), 1);
        tick(nop(), 0, 0);
        check("load-use forward_a", 32'(forward_a), 32'h1);
        check("load-use forward_b", 32'(forward_b), 32'h1);
        repeat (3) tick(nop(), 0, 0);

        // Writes to x0 never forward or stall
        tick(addi0, 0, 0);
        tick(add600, 0, 0);
        check("x0 stall_pc", 32'(stall_pc), 0);
        tick(nop(), 0, 0);
        check("x0 forward_a", 32'(forward_a), 0);
        check("x0 forward_b", 32'(forward_b), 0);
        repeat (3) tick(nop(), 0, 0);

        // Flush beats the load-use hazard
        tick(lw5, 0, 0);
        tick(beq, 1, 0);
        check("flush stall_pc", 32'(stall_pc), 0);
        tick(nop(), 0, 0);
        check("flush forward_rs2", 32'(forward_rs2), 0);
        check("flush count", 32'(stall_count), 1);
        repeat (3) tick(nop(), 0, 0);

        // Link-use: JAL result only available from WB
        tick(jal1, 0, 0);
        tick(addi2, 0, 0);
        check("link-use stall_ifid", 32'(stall_ifid), 1);
        tick(addi2, 0, 0);
        check("link-use released", 32'(stall_ifid), 0);
        tick(nop(), 0, 0);
        check("link-use forward_a", 32'(forward_a), 32'h1);
        check("link-use forward_b", 32'(forward_b), 32'h0);
        check("link-use count", 32'(stall_count), 2);
        repeat (3) tick(nop(), 0, 0);

        // Reset asserted in the middle of a stall
        tick(lw5, 0, 0);
        tick(add655, 0, 0);
        check("pre-reset stall_pc", 32'(stall_pc), 1);
        rst = 1'b1;
        #1;
        check("mid-stall reset stall_pc", 32'(stall_pc), 0);
        check("mid-stall reset bubble_ex", 32'(bubble_ex), 0);
        check("mid-stall reset stall_count", 32'(stall_count), 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        tick(nop(), 0, 0);

        // Randomized traffic with holds and flushes
        r  = nop();
        fl = 0;
        hd = 0;
        for (int n = 0; n < 3000; n++) begin
            keep = m_hazard() || ext_hold;
            if (!keep) begin
                if ($urandom_range(0, 5) == 0) r = nop();
                else r = mk(1, $urandom_range(0, 7), $urandom_range(0, 1),
                            $urandom_range(0, 7), $urandom_range(0, 1),
                            $urandom_range(0, 7), $urandom_range(0, 1),
                            $urandom_range(0, 2), $urandom_range(0, 1),
                            $urandom_range(0, 1));
            end
            if (!(ext_hold && flush)) fl = ($urandom_range(0, 9) == 0);
            hd = ($urandom_range(0, 7) == 0);
            tick(r, fl, hd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Pipeline hazard and forwarding controller for the 5-stage RV32I core. It tracks destination-register metadata for the EX, MEM and WB stages in its own shift registers. From that state it drives the ALU operand-forwarding selects for the instruction in EX. It also detects load-use and link-use hazards against the instruction in ID, inserting one-cycle stalls and bubbles, and applies branch flushes.

## Interface
- REG_W, default 5: register-index width (x0..x31).
- CNT_W, default 32: width of the stall performance counter.

- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  REG_W  source registers of the ID instruction.
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1 / rs2.
- id_rd  in  REG_W  destination register of the ID instruction.
- id_regwrite  in  1  ID instruction writes rd.
- id_wbsel  in  2  writeback source: 00 dmem, 01 ALU, 10 PC+4.
- id_asel, id_bsel  in  1  ALU operand-select bits: 1 = PC / imm, 0 = register.
- flush  in  1  branch or jump resolved taken in EX; kill the ID and EX instructions.
- ext_hold  in  1  memory wait; freeze the whole pipeline, including this block.
- forward_a, forward_b  out  2  ALU operand selects: 10 MEM ALU result, 01 WB data, 00 none.
- forward_rs2  out  2  same encoding, ungated by bsel (store data / branch compare).
- stall_pc, stall_ifid  out  1  hold PC and the IF/ID register.
- bubble_ex  out  1  load a NOP into ID/EX.
- stall_count  out  CNT_W  saturating count of hazard-stall cycles.

## Operation
- Internal stage records EX, MEM and WB. Each holds valid, rd, regwrite and wbsel. EX additionally holds rs1, rs2, use_rs1, use_rs2, asel and bsel.
- Writer definition: a stage "writes r" when valid & regwrite & rd==r & r!=0. x0 never matches.
- Forward select for operand rs, evaluated combinationally from the registered state:
  - If MEM writes rs and MEM.wbsel==01, select 10.
  - Else if WB writes rs, select 01 (WB data covers dmem, ALU and PC+4).
  - Otherwise select 00.
  - MEM takes priority over WB.
- Gating:
  - forward_a = select(EX.rs1) only if EX.use_rs1 & !EX.asel, else 00.
  - forward_b = select(EX.rs2) only if EX.use_rs2 & !EX.bsel, else 00.
  - forward_rs2 = select(EX.rs2) if EX.use_rs2, else 00.
- Hazard: raised when id_valid, EX writes r, EX.wbsel!=01, and the ID instruction uses r (rs1 or rs2). This covers a load or JAL/JALR in EX feeding ID.
  - On hazard: stall_pc=stall_ifid=bubble_ex=1 for exactly one cycle.
  - The next cycle the producer is in MEM and EX holds a bubble, so no hazard is raised and ID advances. The producer then reaches WB when the consumer reaches EX, and the consumer takes the WB forward.
- MEM.wbsel!=01 with a consumer in EX cannot occur, because the hazard stall prevents it. Defensive rule: never select 10 when MEM.wbsel!=01.
- Stage advance on each edge, when ext_hold=0:
  - WB<=MEM.
  - MEM<=EX.
  - EX<=ID fields, or an invalid record if bubble_ex or flush.
- flush: EX<=invalid, and the hazard output is suppressed (flush overrides stall). MEM and WB advance normally.
- ext_hold=1: all records and stall_count hold; outputs are recomputed from the held state.
- stall_count increments once per cycle in which a hazard stall is asserted and ext_hold=0. It saturates at all-ones.

## Timing
- Reset (async, immediate): all stage records invalid; forward_* = 00; stall_pc = stall_ifid = bubble_ex = 0; stall_count = 0.
- Forward selects and stall outputs are combinational from registers plus the ID inputs, valid in the same cycle with zero latency.
- A load-use stall costs exactly 1 cycle.
- Simultaneous flush and hazard: flush wins, no stall, EX bubble.
- Simultaneous ext_hold and flush: hold wins and the flush is ignored. The pipeline owner must keep flush asserted until the hold is released.
- rst asserted mid-stall: outputs drop to their reset values immediately, and no partial record survives.

## Structure
- Package hazard_pkg holds:
  - constants FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - constants WB_DMEM=2'b00, WB_ALU=2'b01, WB_PC4=2'b10;
  - typedef stage_rec_t.
- One sub-module, fwd_select: combinational MEM/WB priority match for a single source register. It is instantiated three times (a, b, rs2).

## Test plan
- add x5,x1,x2 then sub x6,x5,x3: forward_a=10 in sub's EX cycle, no stall.
- add x5 then nop then or x7,x0,x5: forward_b=01, forward_a=00 (rs1=x0).
- lw x5 then add x6,x5,x5: one cycle with stall_pc=bubble_ex=1, then forward_a=forward_b=01; stall_count goes 0 to 1.
- addi x0,x1,4 then add x6,x0,x0: no forward, no stall.
- lw x5 then beq, with flush asserted in the hazard cycle: no stall, EX invalid next cycle.
- jal x1 then addi x2,x1,8 (asel=0, bsel=1): 1-cycle stall, then forward_a=01, forward_b=00.
